// File: rtl/op_sequencer.sv
// Fetch/execute controller for the accumulator datapath.
// Define OP_SEQUENCER_TRAP_EN to make illegal classes trap and halt.
module op_sequencer #(
   parameter int          ADDR_W   = 8,
   parameter logic [7:0]  RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_data,
   input  logic              mem_valid,
   output logic [2:0]        operation_code,
   output logic [7:0]        in_b,
   output logic              aku_enable,
   input  logic [7:0]        alu_result,
   input  logic              carry_in,
   input  logic [7:0]        ext_in,
   output logic [7:0]        out_port,
   output logic              out_strobe,
   input  logic              start,
   output logic              halted,
   output logic              trap
);

   localparam logic [ADDR_W-1:0] PC_RST = RESET_PC[ADDR_W-1:0];

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [15:0]       ir_q;
   logic              carry_q;

   logic [3:0] cls;
   logic       is_imm;
   logic       is_ext;
   logic       is_jmp;
   logic       is_jc;
   logic       is_jnc;
   logic       is_out;
   logic       is_halt;
   logic       is_ill;
   logic       is_alu;
   logic       take_jump;
   logic       trap_stop;
   logic       resume_ok;
   logic       unused_ir;

   assign cls     = ir_q[15:12];
   assign is_imm  = (cls == 4'd1);
   assign is_ext  = (cls == 4'd2);
   assign is_jmp  = (cls == 4'd3);
   assign is_jc   = (cls == 4'd4);
   assign is_jnc  = (cls == 4'd5);
   assign is_out  = (cls == 4'd6);
   assign is_halt = (cls == 4'd7);
   assign is_ill  = cls[3];
   assign is_alu  = is_imm | is_ext;

   assign take_jump = is_jmp
                    | (is_jc  &  carry_q)
                    | (is_jnc & ~carry_q);

   assign unused_ir = ir_q[11];

`ifdef OP_SEQUENCER_TRAP_EN
   logic trap_q;

   // Sticky until reset; blocks start so a trapped core stays parked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trap_q <= 1'b0;
      end else if (state_q == ST_EXEC && is_ill) begin
         trap_q <= 1'b1;
      end
   end

   assign trap      = trap_q;
   assign trap_stop = is_ill;
   assign resume_ok = ~trap_q;
`else
   assign trap      = 1'b0;
   assign trap_stop = 1'b0;
   assign resume_ok = 1'b1;
`endif

   assign mem_addr       = pc_q;
   assign operation_code = ir_q[10:8];
   assign halted         = (state_q == ST_HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_rd     = 1'b0;
      aku_enable = 1'b0;
      in_b       = 8'h00;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            mem_rd = 1'b1;
            if (mem_valid) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            unique case (1'b1)
               is_imm: begin
                  aku_enable = 1'b1;
                  in_b       = ir_q[7:0];
               end
               is_ext: begin
                  aku_enable = 1'b1;
                  in_b       = ext_in;
               end
               is_halt: begin
                  state_d = ST_HALT;
               end
               trap_stop: begin
                  state_d = ST_HALT;
               end
               default: begin
               end
            endcase
         end
         ST_HALT: begin
            if (start && resume_ok) begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Jump overrides the increment already applied during fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= PC_RST;
         ir_q       <= 16'h0000;
         carry_q    <= 1'b0;
         out_port   <= 8'h00;
         out_strobe <= 1'b0;
      end else begin
         out_strobe <= 1'b0;
         if (state_q == ST_FETCH && mem_valid) begin
            ir_q <= mem_data;
            pc_q <= pc_q + ADDR_W'(1);
         end
         if (state_q == ST_EXEC) begin
            if (is_alu) begin
               carry_q <= carry_in;
            end
            if (take_jump) begin
               pc_q <= ir_q[ADDR_W-1:0];
            end
            if (is_out) begin
               out_port   <= alu_result;
               out_strobe <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_op_sequencer.sv
// Randomized bench for op_sequencer against an instruction-level model.
// The model interprets a program image; memory latency is random.
module tb_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_data;
   logic        mem_valid;
   logic [2:0]  operation_code;
   logic [7:0]  in_b;
   logic        aku_enable;
   logic [7:0]  alu_result;
   logic        carry_in;
   logic [7:0]  ext_in;
   logic [7:0]  out_port;
   logic        out_strobe;
   logic        start;
   logic        halted;
   logic        trap;

   op_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_addr       (mem_addr),
      .mem_rd         (mem_rd),
      .mem_data       (mem_data),
      .mem_valid      (mem_valid),
      .operation_code (operation_code),
      .in_b           (in_b),
      .aku_enable     (aku_enable),
      .alu_result     (alu_result),
      .carry_in       (carry_in),
      .ext_in         (ext_in),
      .out_port       (out_port),
      .out_strobe     (out_strobe),
      .start          (start),
      .halted         (halted),
      .trap           (trap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] prog [256];
   logic [7:0]  pc_m;
   logic [7:0]  out_m;
   logic        carry_m;
   logic        strobe_m;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pc_m     = 8'h00;
      out_m    = 8'h00;
      carry_m  = 1'b0;
      strobe_m = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge with the DUT in FETCH.
   task automatic do_reset();
      rst       = 1'b1;
      mem_valid = 1'b0;
      start     = 1'b0;
      #1;
      check("rst_rd", mem_rd, 1'b0);
      check("rst_aku", aku_enable, 1'b0);
      check("rst_halt", halted, 1'b0);
      @(negedge clk);
      check("rst_addr", mem_addr, 8'h00);
      check("rst_op", operation_code, 3'd0);
      check("rst_inb", in_b, 8'h00);
      check("rst_out", out_port, 8'h00);
      check("rst_stb", out_strobe, 1'b0);
      check("rst_trap", trap, 1'b0);
      rst = 1'b0;
      #1;
      check("boot_rd", mem_rd, 1'b0);
      @(negedge clk);
      model_reset();
   endtask

   function automatic logic [15:0] rand_word();
      int r;
      logic [3:0] c;
      r = $urandom_range(0, 99);
      if (r < 25)      c = 4'd1;
      else if (r < 40) c = 4'd2;
      else if (r < 48) c = 4'd3;
      else if (r < 58) c = 4'd4;
      else if (r < 68) c = 4'd5;
      else if (r < 78) c = 4'd6;
      else if (r < 83) c = 4'd7;
      else if (r < 88) c = 4'(8 + $urandom_range(0, 7));
      else             c = 4'd0;
      return {c, 4'($urandom), 8'($urandom)};
   endfunction

   task automatic run_instr();
      int          w;
      logic [15:0] word;
      logic [3:0]  c;
      logic        alu;
      check("fetch_rd", mem_rd, 1'b1);
      check("fetch_addr", mem_addr, pc_m);
      check("strobe", out_strobe, strobe_m);
      check("out_port", out_port, out_m);
      strobe_m = 1'b0;
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) begin
         mem_valid = 1'b0;
         mem_data  = 16'($urandom);
         @(negedge clk);
         check("wait_rd", mem_rd, 1'b1);
         check("wait_addr", mem_addr, pc_m);
         check("wait_aku", aku_enable, 1'b0);
      end
      word      = prog[pc_m];
      mem_valid = 1'b1;
      mem_data  = word;
      @(negedge clk);
      mem_valid  = 1'($urandom);
      mem_data   = 16'($urandom);
      ext_in     = 8'($urandom);
      carry_in   = 1'($urandom);
      alu_result = 8'($urandom);
      #1;
      c    = word[15:12];
      alu  = (c == 4'd1) || (c == 4'd2);
      pc_m = pc_m + 8'd1;
      check("ex_aku", aku_enable, alu);
      check("ex_op", operation_code, word[10:8]);
      check("ex_rd", mem_rd, 1'b0);
      check("ex_stb", out_strobe, 1'b0);
      if (c == 4'd1) check("ex_inb_imm", in_b, word[7:0]);
      if (c == 4'd2) check("ex_inb_ext", in_b, ext_in);
`ifndef OP_SEQUENCER_TRAP_EN
      check("ex_trap", trap, 1'b0);
`endif
      if (alu) carry_m = carry_in;
      if (c == 4'd3) pc_m = word[7:0];
      if (c == 4'd4 && carry_m) pc_m = word[7:0];
      if (c == 4'd5 && !carry_m) pc_m = word[7:0];
      if (c == 4'd6) begin
         out_m    = alu_result;
         strobe_m = 1'b1;
      end
      @(negedge clk);
      mem_valid = 1'b0;
`ifdef OP_SEQUENCER_TRAP_EN
      if (c[3]) begin
         check("trap_set", trap, 1'b1);
         check("trap_halt", halted, 1'b1);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("trap_stay", halted, 1'b1);
         check("trap_rd", mem_rd, 1'b0);
         do_reset();
         return;
      end
`endif
      if (c == 4'd7) begin
         w = $urandom_range(0, 3);
         for (int i = 0; i <= w; i++) begin
            check("halt_h", halted, 1'b1);
            check("halt_rd", mem_rd, 1'b0);
            mem_valid = 1'($urandom);
            @(negedge clk);
         end
         mem_valid = 1'b0;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      check("halted_lo", halted, 1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      mem_valid  = 1'b0;
      mem_data   = 16'h0000;
      start      = 1'b0;
      alu_result = 8'h00;
      carry_in   = 1'b0;
      ext_in     = 8'h00;
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
      repeat (2) @(negedge clk);
      do_reset();

      // Drop reset in the middle of a stalled fetch.
      check("mid_rd", mem_rd, 1'b1);
      do_reset();

      prog[0]     = 16'h160A;
      prog[1]     = 16'h30FF;
      prog[8'hFF] = 16'h0000;
      for (int i = 0; i < 3; i++) run_instr();
      check("wrap_pc", pc_m, 8'h00);

      prog[0] = 16'h7000;
      prog[1] = 16'h6000;
      prog[2] = 16'h9000;
      for (int i = 0; i < 3; i++) run_instr();

      for (int i = 0; i < 256; i++) prog[i] = rand_word();
      for (int i = 0; i < 600; i++) run_instr();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
- Fetch/execute controller for the accumulator datapath (ALU + accumulator with clock enable).
- Reads 16-bit instruction words from a program memory over a valid handshake.
- Decodes each word and drives the datapath's operation code, B operand and accumulator enable.
- Latches carry, performs conditional jumps and exposes an output port.

Parameters:
ADDR_W, 8, program counter / memory address width; legal range 1..8 (jump targets come from the 8-bit immediate).
RESET_PC, 0, PC value loaded on reset; truncated to ADDR_W bits.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous active-high reset.
mem_addr  output  ADDR_W  program memory address (= PC).
mem_rd  output  1  read request.
mem_data  input  16  instruction word.
mem_valid  input  1  mem_data valid this cycle.
operation_code  output  3  ALU operation select.
in_b  output  8  ALU B operand.
aku_enable  output  1  accumulator clock enable.
alu_result  input  8  accumulator output.
carry_in  input  1  ALU carry output.
ext_in  input  8  external data operand.
out_port  output  8  output register.
out_strobe  output  1  one-cycle pulse, out_port updated.
start  input  1  resume from HALT.
halted  output  1  sequencer in HALT.
trap  output  1  illegal-instruction flag (see Optional Feature).

Behaviour:
- Instruction word: [15:12] class; [10:8] ALU op; [7:0] immediate.
- Classes:
  - 0 NOP.
  - 1 ALU_IMM: in_b = imm.
  - 2 ALU_EXT: in_b = ext_in.
  - 3 JMP: PC <= imm.
  - 4 JC: jump if carry_reg = 1.
  - 5 JNC: jump if carry_reg = 0.
  - 6 OUT.
  - 7 HALT.
  - 8-15 illegal.
- Jump target is imm[ADDR_W-1:0].
- States: BOOT, FETCH, EXEC, HALT. Reset state is BOOT.
- Reset values, held while rst is high:
  - PC = RESET_PC; IR = 0; carry_reg = 0.
  - out_port = 0; out_strobe = 0; trap = 0.
  - mem_rd = 0; aku_enable = 0; halted = 0.
  - operation_code = 0; in_b = 0.
- BOOT: outputs idle; unconditionally goes to FETCH next cycle.
- FETCH:
  - mem_rd = 1 and mem_addr = PC, both held stable until mem_valid = 1 is sampled.
  - On that edge: IR <= mem_data; PC <= PC+1 modulo 2^ADDR_W (0xFF -> 0x00 for ADDR_W=8); go to EXEC.
  - Zero-wait memory means mem_valid may be high in the first FETCH cycle.
- mem_valid is ignored in all states other than FETCH.
- EXEC lasts exactly one cycle:
  - operation_code = IR[10:8] combinationally from IR in every state; value is don't-care when aku_enable = 0.
  - ALU_IMM / ALU_EXT: aku_enable = 1 for this single cycle; in_b per class; carry_reg <= carry_in on the same edge.
  - aku_enable = 0 in every other state and class.
  - Jumps: PC <= target when taken, overriding the increment from FETCH; otherwise PC is unchanged.
  - OUT: out_port <= alu_result, i.e. the accumulator value after all previously completed instructions; out_strobe = 1 in the following cycle only.
  - NOP: no effect.
  - HALT: go to HALT.
  - All other classes return to FETCH.
- Minimum instruction time: 2 cycles (FETCH + EXEC). Each mem_valid wait cycle adds 1.
- HALT:
  - halted = 1, mem_rd = 0.
  - start = 1 sampled -> FETCH at the current PC (the word after HALT).
  - start is ignored in all other states.
- Asynchronous reset in any state, including mid-fetch with mem_rd high, forces the reset values immediately.
  - The fetch is abandoned; the memory must tolerate a dropped request.

Optional Feature:
- Macro: OP_SEQUENCER_TRAP_EN.
- Defined: illegal class in EXEC sets trap = 1 (sticky until rst) and enters HALT. start does not leave HALT while trap = 1.
- Undefined: illegal class executes as NOP; trap is tied to 0.

Test Plan:
1. Reset: assert rst mid-FETCH with mem_rd = 1 -> mem_rd/aku_enable/halted drop immediately. After release: one BOOT cycle, then mem_rd = 1 with mem_addr = 0x00.
2. ALU_IMM 0x160A with zero-wait memory -> operation_code = 6 and in_b = 0x0A while aku_enable = 1 for exactly one cycle. Next fetch is at address 0x01, 2 cycles after the first.
3. Wait states: mem_valid low for 3 cycles -> mem_rd and mem_addr held stable, aku_enable stays 0. EXEC occurs the cycle after mem_valid rises.
4. Carry:
   - ALU exec with carry_in = 1, then JC 0x4020 -> next mem_addr = 0x20.
   - Repeat with carry_in = 0 -> next mem_addr = previous PC+1.
   - JNC behaves inversely.
5. Wrap and output:
   - NOP at PC 0xFF -> next fetch at 0x00.
   - OUT with alu_result = 0x5A -> out_port = 0x5A, out_strobe high one cycle.
6. HALT/trap:
   - HALT -> halted = 1, mem_rd = 0; start pulse -> fetch at the following address.
   - Word 0x9000 with OP_SEQUENCER_TRAP_EN -> trap = 1, halted stays 1 despite start.
   - Word 0x9000 without the macro -> executes as NOP.
